// File: rtl/counter_unit.sv
// counter_unit: modulo time-unit counter (seconds / minutes / hours stage).
// Runs on a single clock with a count-enable tick; stages chain through
// carry -> en. Optional 12-hour display mapping and validated parallel load.
// Build option: define COUNTER_UNIT_DOWN_EN to honour up_dn (count down with
// a borrow pulse on carry). Without it the stage counts up only.
module counter_unit #(
    parameter int WIDTH    = 7,
    parameter int MOD_FULL = 24,
    parameter int MOD_HALF = 12
) (
    input  logic             unit_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode_12,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] value,
    output logic             pm,
    output logic             carry,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD_FULL - 1);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(MOD_HALF);
    localparam logic [WIDTH:0]   FULL_EXT = (WIDTH+1)'(MOD_FULL);

    // Compare one bit wider so MOD_FULL == 2**WIDTH still validates correctly.
    logic load_ok;
    assign load_ok = ({1'b0, load_val} < FULL_EXT);

    logic at_last;
    assign at_last = (count == LAST);

`ifdef COUNTER_UNIT_DOWN_EN
    logic at_zero;
    assign at_zero = (count == '0);
`else
    // Direction input has no effect in the up-only build.
    logic unused_up_dn;
    assign unused_up_dn = up_dn;
`endif

    // Count register: reset, then load, then enabled step, else hold.
    always_ff @(posedge unit_clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            carry <= 1'b0;
            if (load_ok) begin
                count    <= load_val;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
        end else if (en) begin
            load_err <= 1'b0;
`ifdef COUNTER_UNIT_DOWN_EN
            if (!up_dn) begin
                if (at_zero) begin
                    count <= LAST;
                    carry <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                    carry <= 1'b0;
                end
            end else
`endif
            if (at_last) begin
                count <= '0;
                carry <= 1'b1;
            end else begin
                count <= count + 1'b1;
                carry <= 1'b0;
            end
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
        end
    end

    // Display mapping: raw count, or 1..MOD_HALF with pm flag in half mode.
    // count < 2*MOD_HALF, so a single conditional subtract gives count mod MOD_HALF.
    logic             half_on;
    logic             upper;
    logic [WIDTH-1:0] rem;
    assign half_on = (MOD_HALF != 0) && mode_12;

    always_comb begin
        upper = 1'b0;
        rem   = count;
        value = count;
        pm    = 1'b0;
        if (half_on) begin
            upper = (count >= HALF);
            rem   = upper ? (count - HALF) : count;
            value = (rem == '0) ? HALF : rem;
            pm    = upper;
        end
    end

endmodule

// File: doc/counter_unit.md
# counter_unit

Parametrised modulo time-unit counter for the digital clock: one block instantiated for seconds, minutes and hours. It runs on the single system clock with a count-enable tick, so stages chain through `carry` instead of ripple clocks. Each stage has an optional 12-hour display mapping, a validated parallel load for time setting, and a wrap-around carry pulse that enables the next stage.

## Interface
Parameters:
- `WIDTH`, 7: width of count, value and load buses; must satisfy 2^WIDTH >= MOD_FULL.
- `MOD_FULL`, 24: modulus of the raw count (60 for sec/min, 24 for hour).
- `MOD_HALF`, 12: 12-hour display modulus. 0 disables half mode. When nonzero it must equal MOD_FULL/2.

Ports:
- `unit_clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count-enable tick, one cycle per unit step. Low means hold (no clear).
- `mode_12`  in  1  1 = 12-hour display mapping, 0 = raw display. Ignored when MOD_HALF = 0.
- `load`  in  1  synchronous load request.
- `load_val`  in  WIDTH  raw value to load, range 0..MOD_FULL-1.
- `up_dn`  in  1  1 = count up, 0 = count down. Honoured only with COUNTER_UNIT_DOWN_EN.
- `count`  out  WIDTH  registered raw count, 0..MOD_FULL-1.
- `value`  out  WIDTH  display value, combinational from `count` and `mode_12`.
- `pm`  out  1  1 when half mode is active and count >= MOD_HALF.
- `carry`  out  1  registered one-cycle pulse on wrap; feeds the next stage's `en`.
- `load_err`  out  1  registered one-cycle pulse on rejected load.

## Operation
- Reset values: count = 0, carry = 0, load_err = 0.
  - Consequence: value = 0 in raw mode, value = MOD_HALF in half mode; pm = 0.
- Priority at each rising edge: rst > load > en > hold.
- Load:
  - If load_val < MOD_FULL: count <= load_val, load_err <= 0.
  - Otherwise: count is unchanged and load_err <= 1.
  - carry <= 0 on any load cycle, valid or rejected.
- Count step (load = 0, en = 1, up direction):
  - count == MOD_FULL-1: count <= 0 and carry <= 1.
  - Otherwise: count <= count+1 and carry <= 0.
- Count step, down direction (macro only):
  - count == 0: count <= MOD_FULL-1 and carry <= 1 (borrow).
  - Otherwise: count <= count-1 and carry <= 0.
- Hold (load = 0, en = 0): count is unchanged; carry <= 0 and load_err <= 0.
- Display mapping:
  - Raw mode (mode_12 = 0 or MOD_HALF = 0): value = count, pm = 0.
  - Half mode: r = count mod MOD_HALF; value = (r == 0) ? MOD_HALF : r; pm = (count >= MOD_HALF).
- Mode switch mid-count never alters count. The display remaps in the same cycle.
- Stage chaining: stage N+1 takes `en` from stage N's `carry`, both on `unit_clk`. A 23:59:59 → 00:00:00 rollover therefore ripples one cycle per stage.
- Arithmetic is WIDTH-bit unsigned. Values outside 0..MOD_FULL-1 can never be stored.

## Timing
- Load to `count`: 1 cycle.
- `en` to `count`: 1 cycle.
- `carry` is high for exactly the cycle after the wrapping edge. It is never high two cycles in a row unless MOD_FULL = 1.
- `value` and `pm` are zero-latency combinational outputs from `count`/`mode_12`.
- Reset asserted mid-operation:
  - count, carry and load_err clear immediately, without waiting for a clock edge.
  - The first count step after rst deasserts requires an `en` at a rising edge.
- `load` and `en` together: load wins, no step occurs, and no carry is produced even if count was MOD_FULL-1.

## Configuration
- Macro: `COUNTER_UNIT_DOWN_EN`.
- Defined: `up_dn` selects direction as described, and `carry` doubles as the borrow pulse when stepping down past 0. Used for countdown-timer mode.
- Undefined: the block is up-count only. `up_dn` is ignored, and no down-count logic is built.

## Test plan
- Reset with MOD_FULL = 24, MOD_HALF = 12, mode_12 = 1 → count = 0, value = 12, pm = 0, carry = 0.
- Load 23, then one en pulse → count = 0, carry high for exactly one cycle. With mode_12 = 1 before the step: value = 11, pm = 1; after the step: value = 12, pm = 0.
- Load 30 with MOD_FULL = 24 → count unchanged, load_err pulses one cycle. Then load 13 with mode_12 = 1 → value = 1, pm = 1.
- load and en asserted together at count = 23 → count = load_val, carry = 0.
- Chain of three stages with moduli 60, 60, 24, loaded to 59, 59, 23, then one en tick → all three stages reach 0 on successive cycles, and the hour stage's carry pulses on the third cycle.
- With COUNTER_UNIT_DOWN_EN, up_dn = 0, count = 0, en → count = MOD_FULL-1 with a one-cycle carry. Assert rst mid-countdown → count = 0 immediately.
